// File: rtl/gray_count_ctrl_pkg.sv
// Shared constants for the 3-bit Gray-code lap sequencer:
// Gray codes, FSM states and direction values.
package gray_ctrl_pkg;

    localparam logic [2:0] G0 = 3'b000;
    localparam logic [2:0] G1 = 3'b001;
    localparam logic [2:0] G2 = 3'b011;
    localparam logic [2:0] G3 = 3'b010;
    localparam logic [2:0] G4 = 3'b110;
    localparam logic [2:0] G5 = 3'b111;
    localparam logic [2:0] G6 = 3'b101;
    localparam logic [2:0] G7 = 3'b100;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/gray_count_ctrl_gray3_step.sv
// Combinational Gray successor: one step up or down the 8-state sequence.
module gray3_step
    import gray_ctrl_pkg::*;
(
    input  logic [2:0] gray,
    input  logic       dir,
    output logic [2:0] next
);

    always_comb begin
        next = G0;
        case (dir)
            DIR_UP: begin
                case (gray)
                    G0: next = G1;
                    G1: next = G2;
                    G2: next = G3;
                    G3: next = G4;
                    G4: next = G5;
                    G5: next = G6;
                    G6: next = G7;
                    G7: next = G0;
                    default: next = G0;
                endcase
            end
            DIR_DN: begin
                case (gray)
                    G0: next = G7;
                    G7: next = G6;
                    G6: next = G5;
                    G5: next = G4;
                    G4: next = G3;
                    G3: next = G2;
                    G2: next = G1;
                    G1: next = G0;
                    default: next = G0;
                endcase
            end
            default: next = G0;
        endcase
    end

endmodule

// File: rtl/gray_count_ctrl.sv
// Lap sequencer for a 3-bit Gray counter: start/pause/abort control,
// lap counting with optional target, registered wrap and done pulses.
module gray_count_ctrl
    import gray_ctrl_pkg::*;
#(
    parameter int unsigned LAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LAP_W-1:0] lap_cnt,
    input  logic             dir,
    input  logic             pause,
    input  logic             abort,
    output logic [2:0]       gray,
    output logic             wrap,
    output logic [LAP_W-1:0] laps_done,
    output logic             busy,
    output logic             done
);

    state_t             state, state_n;
    logic [2:0]         gray_q, gray_n, gray_step;
    logic [LAP_W-1:0]   laps_q, laps_n, laps_inc;
    logic [LAP_W-1:0]   tgt_q, tgt_n;
    logic               dir_q, dir_n;
    logic               wrap_q, wrap_n;

    gray3_step u_step (
        .gray (gray_q),
        .dir  (dir_q),
        .next (gray_step)
    );

    assign laps_inc = laps_q + LAP_W'(1);

    always_comb begin
        state_n = state;
        gray_n  = gray_q;
        laps_n  = laps_q;
        tgt_n   = tgt_q;
        dir_n   = dir_q;
        wrap_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                gray_n = G0;
                if (start) begin
                    tgt_n   = lap_cnt;
                    dir_n   = dir;
                    laps_n  = '0;
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    gray_n  = G0;
                    laps_n  = '0;
                    state_n = ST_IDLE;
                end else if (pause) begin
                    state_n = ST_PAUSED;
                end else begin
                    gray_n = gray_step;
                    if (gray_step == G0) begin
                        wrap_n = 1'b1;
                        laps_n = laps_inc;
                        // Target 0 is free-run: never terminates on lap count.
                        if (tgt_q != '0 && laps_inc == tgt_q)
                            state_n = ST_DONE;
                    end
                end
            end
            ST_PAUSED: begin
                if (abort) begin
                    gray_n  = G0;
                    laps_n  = '0;
                    state_n = ST_IDLE;
                end else if (!pause) begin
                    state_n = ST_RUN;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                gray_n  = G0;
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            gray_q <= G0;
            laps_q <= '0;
            tgt_q  <= '0;
            dir_q  <= DIR_UP;
            wrap_q <= 1'b0;
        end else begin
            state  <= state_n;
            gray_q <= gray_n;
            laps_q <= laps_n;
            tgt_q  <= tgt_n;
            dir_q  <= dir_n;
            wrap_q <= wrap_n;
        end
    end

    assign gray      = gray_q;
    assign wrap      = wrap_q;
    assign laps_done = laps_q;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

endmodule
